prewish_mask_arbiter: RTL and testbench

- Shares the mask-loading mentor's student-side strobe/data interface among NREQ requesters, for example a button handler, a UART command path and a test sequencer.
- Grants one requester at a time in round-robin order.
- For each grant: latches that requester's 8-bit mask, drives a fixed-width strobe into the mentor, then holds off for a fixed gap so the mentor can complete its load/strobe sequence before the next grant.

---
 rtl/prewish_mask_arbiter_if.sv | 25 ++
 rtl/prewish_mask_arbiter.sv | 142 ++++++++++++++
 tb/tb_prewish_mask_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prewish_mask_arbiter_if.sv
// Requester-side bundle for the mask arbiter: level requests and their mask
// slices in, one-hot acknowledge plus the mentor strobe/data pair out.
interface prewish_mask_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   REQ_I;
  logic [NREQ*8-1:0] DAT_I;
  logic [NREQ-1:0]   ACK_O;
  logic              STB_O;
  logic [7:0]        DAT_O;
  logic              BUSY_O;
  logic [2:0]        GNT_IDX_O;

  // Requester / stimulus side.
  modport master (
    output REQ_I, DAT_I,
    input  ACK_O, STB_O, DAT_O, BUSY_O, GNT_IDX_O
  );

  // Arbiter side.
  modport slave (
    input  REQ_I, DAT_I,
    output ACK_O, STB_O, DAT_O, BUSY_O, GNT_IDX_O
  );
endinterface

// File: rtl/prewish_mask_arbiter.sv
// Round-robin arbiter in front of the mask-loading mentor. Each grant latches
// the winner's 8-bit mask, drives a STB_CYCLES-wide strobe and then holds off
// for GAP_CYCLES so the mentor can finish its load before the next grant.
// Every output is a flop; nothing combinational reaches the ports.
module prewish_mask_arbiter #(
  parameter int NREQ       = 4,
  parameter int STB_CYCLES = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  prewish_mask_arbiter_if.slave  bus
);

  localparam int MAXC = (STB_CYCLES > GAP_CYCLES) ? STB_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set request at or above ptr, wrapping modulo NREQ.
  function automatic pick_t pick_next(input logic [NREQ-1:0] req,
                                      input logic [2:0]      ptr);
    pick_t p;
    int    pos;
    p = '0;
    // Walk downward so the nearest candidate to ptr is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (1'(req >> pos)) begin
        p.found = 1'b1;
        p.idx   = 3'(pos);
      end
    end
    return p;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [2:0]      ptr_q,   ptr_d;
  logic            stb_q,   stb_d;
  logic [7:0]      dat_q,   dat_d;
  logic [NREQ-1:0] ack_q,   ack_d;
  logic [2:0]      gnt_q,   gnt_d;
  logic            busy_q,  busy_d;
  pick_t           sel;

  // Next-state and next-output logic for the IDLE/STROBE/GAP sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    stb_d   = stb_q;
    dat_d   = dat_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    sel     = pick_next(bus.REQ_I, ptr_q);

    unique case (state_q)
      IDLE: begin
        if (sel.found) begin
          dat_d   = 8'(bus.DAT_I >> {sel.idx, 3'b000});
          stb_d   = 1'b1;
          ack_d   = NREQ'(1) << sel.idx;
          gnt_d   = sel.idx;
          ptr_d   = (sel.idx == 3'(NREQ - 1)) ? 3'd0 : sel.idx + 3'd1;
          cnt_d   = CW'(STB_CYCLES - 1);
          state_d = STROBE;
        end else begin
          stb_d = 1'b0;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          stb_d   = 1'b0;
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        // Requests are deliberately not looked at here.
        stb_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the strobe and ack at once.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      stb_q   <= 1'b0;
      dat_q   <= 8'h00;
      ack_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values and the
      // update order inside this block does not matter.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.STB_O     = stb_q;
  assign bus.DAT_O     = dat_q;
  assign bus.ACK_O     = ack_q;
  assign bus.GNT_IDX_O = gnt_q;
  assign bus.BUSY_O    = busy_q;

endmodule

// File: tb/tb_prewish_mask_arbiter.sv
// Bench for prewish_mask_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a timeline model of grants.
module tb_prewish_mask_arbiter;

  localparam int NREQ = 4;
  localparam int STB  = 2;
  localparam int GAP  = 4;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;

  always #5 CLK_I = ~CLK_I;

  prewish_mask_arbiter_if #(.NREQ(NREQ)) bus_if ();

  prewish_mask_arbiter #(
    .NREQ       (NREQ),
    .STB_CYCLES (STB),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a grant starts a window of STB+GAP busy cycles, the
  // first STB of which carry the strobe.
  int              m_ptr;
  bit              m_busy;
  int              m_t;
  logic            m_stb;
  logic [7:0]      m_dat;
  logic [NREQ-1:0] m_ack;
  logic [2:0]      m_gnt;

  int   cyc = 0;
  int   ack1_seen;
  logic stb_prev = 1'b0;
  int   rise_cyc[$];
  int   rise_gnt[$];
  int   rise_dat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr  = 0;
    m_busy = 1'b0;
    m_t    = 0;
    m_stb  = 1'b0;
    m_dat  = 8'h00;
    m_ack  = '0;
    m_gnt  = 3'd0;
  endtask

  task automatic m_edge(input logic [NREQ-1:0] req, input logic [NREQ*8-1:0] dat);
    int idx;
    m_ack = '0;
    if (m_busy) begin
      m_t++;
      m_stb  = (m_t < STB);
      m_busy = (m_t < STB + GAP);
    end else if (req != '0) begin
      idx = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (idx < 0 && req[(m_ptr + k) % NREQ]) idx = (m_ptr + k) % NREQ;
      end
      m_gnt  = 3'(idx);
      m_dat  = 8'(dat >> (8 * idx));
      m_ack  = NREQ'(1) << idx;
      m_ptr  = (idx + 1) % NREQ;
      m_t    = 0;
      m_stb  = 1'b1;
      m_busy = 1'b1;
    end else begin
      m_stb = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".stb"},  32'(bus_if.STB_O),     32'(m_stb));
    check({tag, ".dat"},  32'(bus_if.DAT_O),     32'(m_dat));
    check({tag, ".ack"},  32'(bus_if.ACK_O),     32'(m_ack));
    check({tag, ".busy"}, 32'(bus_if.BUSY_O),    32'(m_busy));
    check({tag, ".gnt"},  32'(bus_if.GNT_IDX_O), 32'(m_gnt));
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs are
  // compared on the following falling edge.
  task automatic step(input string tag);
    @(posedge CLK_I);
    if (RST_I) m_edge(bus_if.REQ_I, bus_if.DAT_I);
    @(negedge CLK_I);
    cyc++;
    compare_all(tag);
    if (bus_if.ACK_O[1]) ack1_seen++;
    if (bus_if.STB_O && !stb_prev) begin
      rise_cyc.push_back(cyc);
      rise_gnt.push_back(int'(bus_if.GNT_IDX_O));
      rise_dat.push_back(int'(bus_if.DAT_O));
    end
    stb_prev = bus_if.STB_O;
  endtask

  // Reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    @(negedge CLK_I);
    #2 RST_I = 1'b0;
    m_reset();
    @(negedge CLK_I);
    RST_I = 1'b1;
  endtask

  initial begin
    int stb_cnt, busy_cnt, guard;

    bus_if.REQ_I = '0;
    bus_if.DAT_I = '0;
    m_reset();
    #1;
    check("rst.stb",  32'(bus_if.STB_O),     32'd0);
    check("rst.dat",  32'(bus_if.DAT_O),     32'h00);
    check("rst.ack",  32'(bus_if.ACK_O),     32'd0);
    check("rst.busy", 32'(bus_if.BUSY_O),    32'd0);
    check("rst.gnt",  32'(bus_if.GNT_IDX_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;

    // Idle with no requests.
    repeat (20) step("idle");

    // Single one-cycle request from requester 2.
    bus_if.DAT_I = {8'h33, 8'hA5, 8'h22, 8'h11};
    bus_if.REQ_I = 4'b0100;
    step("t2");
    bus_if.REQ_I = '0;
    check("t2.ack_first", 32'(bus_if.ACK_O),     32'h4);
    check("t2.gnt_first", 32'(bus_if.GNT_IDX_O), 32'd2);
    check("t2.dat_first", 32'(bus_if.DAT_O),     32'hA5);
    stb_cnt  = int'(bus_if.STB_O);
    busy_cnt = int'(bus_if.BUSY_O);
    repeat (10) begin
      step("t2");
      stb_cnt  += int'(bus_if.STB_O);
      busy_cnt += int'(bus_if.BUSY_O);
    end
    check("t2.stb_width",  32'(stb_cnt),       32'(STB));
    check("t2.busy_width", 32'(busy_cnt),      32'(STB + GAP));
    check("t2.dat_hold",   32'(bus_if.DAT_O),  32'hA5);

    // All requesters held: rotation from pointer 0 with fixed spacing.
    do_reset();
    bus_if.DAT_I = {8'h13, 8'h12, 8'h11, 8'h10};
    bus_if.REQ_I = 4'b1111;
    rise_cyc.delete(); rise_gnt.delete(); rise_dat.delete();
    guard = 0;
    while (rise_cyc.size() < 5 && guard < 60) begin
      step("t3");
      guard++;
    end
    check("t3.rises", 32'(rise_cyc.size()), 32'd5);
    for (int i = 0; i < rise_cyc.size(); i++) begin
      check("t3.gnt_order", 32'(rise_gnt[i]), 32'(i % NREQ));
      check("t3.dat_order", 32'(rise_dat[i]), 32'(8'h10 + (i % NREQ)));
      if (i > 0) check("t3.spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'(STB + GAP + 1));
    end
    bus_if.REQ_I = '0;
    repeat (STB + GAP + 2) step("t3_drain");

    // Pointer wrap: after a grant to 3, requesters 0 and 3 both ask.
    do_reset();
    bus_if.REQ_I = 4'b1000;
    step("t4");
    bus_if.REQ_I = '0;
    check("t4.gnt3", 32'(bus_if.GNT_IDX_O), 32'd3);
    repeat (STB + GAP + 1) step("t4");
    bus_if.REQ_I = 4'b1001;
    step("t4");
    bus_if.REQ_I = '0;
    check("t4.wrap_gnt", 32'(bus_if.GNT_IDX_O), 32'd0);
    check("t4.wrap_ack", 32'(bus_if.ACK_O),     32'h1);
    repeat (STB + GAP + 2) step("t4_drain");

    // Asynchronous reset in the middle of a strobe.
    bus_if.REQ_I = 4'b0010;
    step("t5");
    bus_if.REQ_I = '0;
    check("t5.stb_before", 32'(bus_if.STB_O), 32'd1);
    #2 RST_I = 1'b0;
    m_reset();
    #1;
    check("t5.stb_async",  32'(bus_if.STB_O),  32'd0);
    check("t5.ack_async",  32'(bus_if.ACK_O),  32'd0);
    check("t5.busy_async", 32'(bus_if.BUSY_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (5) step("t5_idle");
    bus_if.REQ_I = 4'b1111;
    step("t5");
    bus_if.REQ_I = '0;
    check("t5.ptr_zero", 32'(bus_if.GNT_IDX_O), 32'd0);
    repeat (STB + GAP + 2) step("t5_drain");

    // Requester 1 asks only during GAP and withdraws before IDLE.
    bus_if.REQ_I = 4'b0001;
    step("t6");
    bus_if.REQ_I = '0;
    repeat (3) step("t6");
    ack1_seen = 0;
    rise_cyc.delete(); rise_gnt.delete(); rise_dat.delete();
    bus_if.REQ_I = 4'b0010;
    repeat (2) step("t6");
    bus_if.REQ_I = '0;
    repeat (10) step("t6");
    check("t6.no_ack1",   32'(ack1_seen),       32'd0);
    check("t6.no_strobe", 32'(rise_cyc.size()), 32'd0);

    // Random traffic against the model.
    repeat (400) begin
      bus_if.REQ_I = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      bus_if.DAT_I = {$urandom, $urandom} >> (64 - NREQ * 8);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
